// File: rtl/gbt_link_ctrl_if.sv
// Signal bundles for gbt_link_ctrl: the clock/reset pair and the GBT/SFP
// control and status signals.

interface gbt_clk_rs_if;
  logic clk;
  logic reset;

  modport master (output clk, output reset);
  modport slave  (input clk, input reset);
endinterface

interface gbt_link_ctrl_if;
  logic        enable_i;
  logic        force_reset_i;
  logic        sfp_los_i;
  logic        gbt_tx_aligned_i;
  logic        gbt_rx_ready_i;
  logic        gbt_general_reset_o;
  logic        gbt_manual_reset_tx_o;
  logic        gbt_manual_reset_rx_o;
  logic        sfp_txdisable_o;
  logic        link_up_o;
  logic [2:0]  state_o;
  logic [7:0]  retry_cnt_o;
  logic [15:0] lost_cnt_o;

  modport master (
    output enable_i, force_reset_i, sfp_los_i, gbt_tx_aligned_i, gbt_rx_ready_i,
    input  gbt_general_reset_o, gbt_manual_reset_tx_o, gbt_manual_reset_rx_o,
    input  sfp_txdisable_o, link_up_o, state_o, retry_cnt_o, lost_cnt_o
  );

  modport slave (
    input  enable_i, force_reset_i, sfp_los_i, gbt_tx_aligned_i, gbt_rx_ready_i,
    output gbt_general_reset_o, gbt_manual_reset_tx_o, gbt_manual_reset_rx_o,
    output sfp_txdisable_o, link_up_o, state_o, retry_cnt_o, lost_cnt_o
  );
endinterface

// File: rtl/gbt_link_ctrl.sv
// GBT link bring-up sequencer: general reset, TX/RX manual reset pulses, lock waits with retry/fault.
// Optional RX-ready debounce is compiled in with `define GBT_LINK_CTRL_DEBOUNCE_EN.

module gbt_link_ctrl #(
  parameter int RESET_CYCLES  = 40,
  parameter int LOCK_TIMEOUT  = 4000000,
  parameter int RETRY_MAX     = 7,
  parameter int STABLE_CYCLES = 256
) (
  gbt_clk_rs_if.slave    ClkRs_ix,
  gbt_link_ctrl_if.slave gbt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_RESET = 3'd1,
    TX_WAIT  = 3'd2,
    RX_RESET = 3'd3,
    RX_WAIT  = 3'd4,
    LINK_UP  = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [31:0] RESET_LOAD = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic [7:0]  retry_cnt_reg, retry_cnt_next;
  logic [15:0] lost_cnt_reg, lost_cnt_next;

  logic        timer_done;
  logic        link_active;
  logic        rx_qualified;
  logic        retry_exhausted;
  logic [7:0]  retry_inc;
  logic [15:0] lost_inc;

  assign timer_done      = (timer_reg == 32'd0);
  assign link_active     = state_reg inside {TX_RESET, TX_WAIT, RX_RESET, RX_WAIT, LINK_UP};
  assign retry_inc       = (&retry_cnt_reg) ? retry_cnt_reg : retry_cnt_reg + 8'd1;
  assign lost_inc        = (&lost_cnt_reg) ? lost_cnt_reg : lost_cnt_reg + 16'd1;
  assign retry_exhausted = ((32'(retry_cnt_reg) + 32'd1) == 32'(RETRY_MAX));

`ifdef GBT_LINK_CTRL_DEBOUNCE_EN
  // Count of consecutive ready clocks seen so far in RX_WAIT, excluding the current one.
  localparam logic [31:0] STABLE_LAST = (STABLE_CYCLES > 1) ? 32'(STABLE_CYCLES - 1) : 32'd0;

  logic [31:0] stable_cnt_reg, stable_cnt_next;

  assign rx_qualified = gbt.gbt_rx_ready_i && (stable_cnt_reg >= STABLE_LAST);

  always_comb begin
    stable_cnt_next = '0;
    if (state_reg == RX_WAIT && state_next == RX_WAIT && gbt.gbt_rx_ready_i) begin
      stable_cnt_next = stable_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      stable_cnt_reg <= '0;
    end else begin
      stable_cnt_reg <= stable_cnt_next;
    end
  end
`else
  logic unused_stable_cycles;

  assign unused_stable_cycles = ^32'(STABLE_CYCLES);
  assign rx_qualified         = gbt.gbt_rx_ready_i;
`endif

  always_comb begin
    state_next     = state_reg;
    retry_cnt_next = retry_cnt_reg;
    lost_cnt_next  = lost_cnt_reg;

    if (gbt.force_reset_i || !gbt.enable_i) begin
      state_next = IDLE;
    end else if (gbt.sfp_los_i && link_active) begin
      state_next = IDLE;
      if (state_reg == LINK_UP) begin
        lost_cnt_next = lost_inc;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (!gbt.sfp_los_i) begin
            state_next = TX_RESET;
          end
        end
        TX_RESET: begin
          if (timer_done) begin
            state_next = TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (gbt.gbt_tx_aligned_i) begin
            state_next = RX_RESET;
          end else if (timer_done) begin
            if (retry_exhausted) begin
              state_next = FAULT;
            end else begin
              state_next     = TX_RESET;
              retry_cnt_next = retry_inc;
            end
          end
        end
        RX_RESET: begin
          if (timer_done) begin
            state_next = RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (rx_qualified) begin
            state_next     = LINK_UP;
            retry_cnt_next = '0;
          end else if (timer_done) begin
            if (retry_exhausted) begin
              state_next = FAULT;
            end else begin
              state_next     = RX_RESET;
              retry_cnt_next = retry_inc;
            end
          end
        end
        LINK_UP: begin
          // Losing TX alignment forces a full TX restart even if RX also dropped.
          if (!gbt.gbt_tx_aligned_i) begin
            state_next    = TX_RESET;
            lost_cnt_next = lost_inc;
          end else if (!gbt.gbt_rx_ready_i) begin
            state_next    = RX_RESET;
            lost_cnt_next = lost_inc;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    timer_next = timer_done ? 32'd0 : timer_reg - 32'd1;
    if (state_next != state_reg) begin
      case (state_next)
        TX_RESET, RX_RESET: timer_next = RESET_LOAD;
        TX_WAIT, RX_WAIT:   timer_next = LOCK_LOAD;
        default:            timer_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      retry_cnt_reg <= '0;
      lost_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      retry_cnt_reg <= retry_cnt_next;
      lost_cnt_reg  <= lost_cnt_next;
    end
  end

  assign gbt.gbt_general_reset_o   = (state_reg == IDLE);
  assign gbt.gbt_manual_reset_tx_o = (state_reg == TX_RESET);
  assign gbt.gbt_manual_reset_rx_o = (state_reg == RX_RESET);
  assign gbt.sfp_txdisable_o       = !link_active;
  assign gbt.link_up_o             = (state_reg == LINK_UP);
  assign gbt.state_o               = state_reg;
  assign gbt.retry_cnt_o           = retry_cnt_reg;
  assign gbt.lost_cnt_o            = lost_cnt_reg;

endmodule

// File: tb/tb_gbt_link_ctrl.sv
// Directed bench for gbt_link_ctrl with a cycle-level reference model and literal pins.
// Honours `define GBT_LINK_CTRL_DEBOUNCE_EN for the debounce build.

module tb_gbt_link_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int RM = 2;
  localparam int SC = 8;
`ifdef GBT_LINK_CTRL_DEBOUNCE_EN
  localparam int QUAL_RUN = SC;
`else
  localparam int QUAL_RUN = 1;
`endif

  gbt_clk_rs_if    cr ();
  gbt_link_ctrl_if g ();

  gbt_link_ctrl #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .RETRY_MAX     (RM),
    .STABLE_CYCLES (SC)
  ) dut (
    .ClkRs_ix (cr),
    .gbt      (g)
  );

  initial cr.clk = 1'b0;
  always #5 cr.clk = ~cr.clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: state codes, clocks spent in the state, retry/lost counts, ready run length.
  int m_state = 0;
  int m_age   = 0;
  int m_retry = 0;
  int m_lost  = 0;
  int m_run   = 0;
  bit m_valid = 1'b0;

  always @(posedge cr.clk) begin : model_step
    int nxt;
    int run_now;
    nxt     = m_state;
    run_now = 0;
    if (cr.reset) begin
      m_state = 0; m_age = 0; m_retry = 0; m_lost = 0; m_run = 0;
      m_valid = 1'b1;
    end else begin
      if (g.force_reset_i || !g.enable_i) begin
        nxt = 0;
      end else if (g.sfp_los_i && m_state >= 1 && m_state <= 5) begin
        nxt = 0;
        if (m_state == 5 && m_lost < 65535) m_lost = m_lost + 1;
      end else begin
        case (m_state)
          0: nxt = g.sfp_los_i ? 0 : 1;
          1: if (m_age == RC - 1) nxt = 2;
          2: begin
            if (g.gbt_tx_aligned_i) nxt = 3;
            else if (m_age == LT - 1) begin
              if (m_retry + 1 == RM) nxt = 6;
              else begin nxt = 1; if (m_retry < 255) m_retry = m_retry + 1; end
            end
          end
          3: if (m_age == RC - 1) nxt = 4;
          4: begin
            run_now = g.gbt_rx_ready_i ? m_run + 1 : 0;
            if (run_now >= QUAL_RUN) begin nxt = 5; m_retry = 0; end
            else if (m_age == LT - 1) begin
              if (m_retry + 1 == RM) nxt = 6;
              else begin nxt = 3; if (m_retry < 255) m_retry = m_retry + 1; end
            end
          end
          5: begin
            if (!g.gbt_tx_aligned_i) begin nxt = 1; if (m_lost < 65535) m_lost = m_lost + 1; end
            else if (!g.gbt_rx_ready_i) begin nxt = 3; if (m_lost < 65535) m_lost = m_lost + 1; end
          end
          6: nxt = 6;
          default: nxt = 0;
        endcase
      end
      m_run   = (m_state == 4 && nxt == 4) ? run_now : 0;
      m_age   = (nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
    end
  end

  always @(negedge cr.clk) begin
    if (m_valid) begin
      check("cycle_outputs",
            {32'd0, g.state_o, g.gbt_general_reset_o, g.gbt_manual_reset_tx_o,
             g.gbt_manual_reset_rx_o, g.sfp_txdisable_o, g.link_up_o, g.retry_cnt_o, g.lost_cnt_o},
            {32'd0, 3'(m_state), m_state == 0, m_state == 1, m_state == 3,
             !(m_state >= 1 && m_state <= 5), m_state == 5, 8'(m_retry), 16'(m_lost)});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cr.clk);
  endtask

  task automatic wait_state(input int s, input string name);
    int k;
    k = 0;
    while (g.state_o != 3'(s) && k < 200) begin
      @(negedge cr.clk);
      k++;
    end
    if (k >= 200) check({name, "_wait_expired"}, 64'(g.state_o), 64'(s));
  endtask

  int tx_cnt;
  int rx_cnt;
  int cyc;
  bit saw_link;

  initial begin
    cr.reset = 1'b1;
    g.enable_i = 1'b0; g.force_reset_i = 1'b0; g.sfp_los_i = 1'b0;
    g.gbt_tx_aligned_i = 1'b0; g.gbt_rx_ready_i = 1'b0;
    tick(2);
    check("reset_state", 64'(g.state_o), 64'd0);
    check("reset_general", 64'(g.gbt_general_reset_o), 64'd1);
    check("reset_txdisable", 64'(g.sfp_txdisable_o), 64'd1);
    check("reset_counters", {32'd0, 8'(g.retry_cnt_o), 8'd0, g.lost_cnt_o}, 64'd0);
    cr.reset = 1'b0;

    // Nominal bring-up
    g.enable_i = 1'b1; g.gbt_tx_aligned_i = 1'b1; g.gbt_rx_ready_i = 1'b1;
    tx_cnt = 0; rx_cnt = 0; cyc = 0;
    while (!g.link_up_o && cyc < 100) begin
      tick(1);
      cyc++;
      if (g.gbt_manual_reset_tx_o) tx_cnt++;
      if (g.gbt_manual_reset_rx_o) rx_cnt++;
    end
    check("nom_tx_pulse_len", 64'(tx_cnt), 64'd4);
    check("nom_rx_pulse_len", 64'(rx_cnt), 64'd4);
    check("nom_state", 64'(g.state_o), 64'd5);
    check("nom_latency", 64'(cyc), 64'(QUAL_RUN == 1 ? 11 : 18));

    // RX ready drops for one clock in LINK_UP
    tick(2);
    g.gbt_rx_ready_i = 1'b0;
    tick(1);
    g.gbt_rx_ready_i = 1'b1;
    check("rxloss_state", 64'(g.state_o), 64'd3);
    check("rxloss_lost", 64'(g.lost_cnt_o), 64'd1);
    wait_state(5, "rxloss_relink");
    check("rxloss_relink_retry", 64'(g.retry_cnt_o), 64'd0);

    // LOS and TX alignment loss together in LINK_UP
    tick(2);
    g.sfp_los_i = 1'b1; g.gbt_tx_aligned_i = 1'b0;
    tick(1);
    check("los_state", 64'(g.state_o), 64'd0);
    check("los_lost", 64'(g.lost_cnt_o), 64'd2);
    tick(2);
    check("los_lost_once", 64'(g.lost_cnt_o), 64'd2);

    // TX timeout then recovery clears retry_cnt
    g.sfp_los_i = 1'b0;
    wait_state(2, "txto1");
    tick(19);
    check("txto1_before", {56'd0, 5'(g.state_o), g.retry_cnt_o[2:0]}, {56'd0, 5'd2, 3'd0});
    tick(1);
    check("txto1_state", 64'(g.state_o), 64'd1);
    check("txto1_retry", 64'(g.retry_cnt_o), 64'd1);
    g.gbt_tx_aligned_i = 1'b1;
    wait_state(5, "txto1_relink");
    check("relink_retry_clear", 64'(g.retry_cnt_o), 64'd0);

    // Two TX timeouts reach FAULT
    g.enable_i = 1'b0;
    tick(1);
    check("disable_state", 64'(g.state_o), 64'd0);
    g.gbt_tx_aligned_i = 1'b0; g.enable_i = 1'b1;
    wait_state(2, "txto2");
    tick(20);
    check("txto2_retry", 64'(g.retry_cnt_o), 64'd1);
    wait_state(2, "txto3");
    tick(19);
    check("txto3_before", 64'(g.state_o), 64'd2);
    tick(1);
    check("fault_state", 64'(g.state_o), 64'd6);
    check("fault_txdisable", 64'(g.sfp_txdisable_o), 64'd1);
    check("fault_retry", 64'(g.retry_cnt_o), 64'd1);
    tick(5);
    check("fault_hold", 64'(g.state_o), 64'd6);
    g.force_reset_i = 1'b1;
    tick(1);
    g.force_reset_i = 1'b0;
    check("force_idle", 64'(g.state_o), 64'd0);

    // LOS in TX_WAIT leaves retry_cnt alone
    wait_state(2, "los_txwait");
    g.sfp_los_i = 1'b1;
    tick(1);
    check("los_txwait_state", 64'(g.state_o), 64'd0);
    check("los_txwait_retry", 64'(g.retry_cnt_o), 64'd1);
    g.sfp_los_i = 1'b0;

    // Reset during the 2nd clock of a TX_RESET pulse
    wait_state(1, "mid_reset");
    tick(1);
    check("mid_reset_pulse", 64'(g.gbt_manual_reset_tx_o), 64'd1);
    cr.reset = 1'b1; g.enable_i = 1'b0;
    tick(1);
    check("mid_reset_mtx", 64'(g.gbt_manual_reset_tx_o), 64'd0);
    check("mid_reset_general", 64'(g.gbt_general_reset_o), 64'd1);
    check("mid_reset_counters", {32'd0, 8'(g.retry_cnt_o), 8'd0, g.lost_cnt_o}, 64'd0);
    cr.reset = 1'b0;

    // RX qualification and RX timeout
    g.enable_i = 1'b1; g.gbt_tx_aligned_i = 1'b1; g.gbt_rx_ready_i = 1'b0;
    wait_state(4, "rxq");
`ifdef GBT_LINK_CTRL_DEBOUNCE_EN
    saw_link = 1'b0;
    for (int i = 0; i < 20; i++) begin
      g.gbt_rx_ready_i = (i % 4 != 3);
      tick(1);
      if (g.link_up_o) saw_link = 1'b1;
    end
    check("deb_no_link", 64'(saw_link), 64'd0);
    check("deb_rxto_state", 64'(g.state_o), 64'd3);
    check("deb_rxto_retry", 64'(g.retry_cnt_o), 64'd1);
    wait_state(4, "deb_link");
    g.gbt_rx_ready_i = 1'b1;
    tick(7);
    check("deb_still_wait", 64'(g.state_o), 64'd4);
    tick(1);
    check("deb_link_state", 64'(g.state_o), 64'd5);
    check("deb_link_retry", 64'(g.retry_cnt_o), 64'd0);
`else
    tick(19);
    check("rxto_before", 64'(g.state_o), 64'd4);
    tick(1);
    check("rxto_state", 64'(g.state_o), 64'd3);
    check("rxto_retry", 64'(g.retry_cnt_o), 64'd1);
    wait_state(4, "rx_single");
    g.gbt_rx_ready_i = 1'b1;
    tick(1);
    check("rx_single_link", 64'(g.state_o), 64'd5);
    check("rx_single_retry", 64'(g.retry_cnt_o), 64'd0);
`endif
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
